// File: rtl/lsu_dmem_req_if.sv
// Load/store request bus between the pipeline memory stage, lsu_dmem_req and the data memory.
//   req_*   : request from pipeline (valid/ready handshake, op, funct3, address, store data)
//   dmem_*  : data-memory port (active-low cs/wr, lane mask, address, write/read data)
//   rsp_*   : completion pulse, extended load data and misalignment flags
// slave modport is the request generator; master modport is the pipeline/memory side.
interface lsu_dmem_req_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_ld_i;
  logic            req_st_i;
  logic [2:0]      req_funct3_i;
  logic [XLEN-1:0] req_addr_i;
  logic [XLEN-1:0] req_st_data_i;
  logic            dmem_cs_o;
  logic            dmem_wr_o;
  logic [3:0]      dmem_mask_o;
  logic [XLEN-1:0] dmem_addr_o;
  logic [XLEN-1:0] dmem_data_wr_o;
  logic [XLEN-1:0] dmem_data_rd_i;
  logic            rsp_valid_o;
  logic [XLEN-1:0] rsp_data_o;
  logic            ld_misalign_o;
  logic            st_misalign_o;

  modport slave (
    input  req_valid_i, req_ld_i, req_st_i, req_funct3_i, req_addr_i, req_st_data_i,
           dmem_data_rd_i,
    output req_ready_o, dmem_cs_o, dmem_wr_o, dmem_mask_o, dmem_addr_o, dmem_data_wr_o,
           rsp_valid_o, rsp_data_o, ld_misalign_o, st_misalign_o
  );

  modport master (
    output req_valid_i, req_ld_i, req_st_i, req_funct3_i, req_addr_i, req_st_data_i,
           dmem_data_rd_i,
    input  req_ready_o, dmem_cs_o, dmem_wr_o, dmem_mask_o, dmem_addr_o, dmem_data_wr_o,
           rsp_valid_o, rsp_data_o, ld_misalign_o, st_misalign_o
  );
endinterface

// File: rtl/lsu_dmem_req.sv
// Load/store request generator for the data-memory port.
// Accepts one load/store in IDLE, drives one registered memory access (ACCESS), then pulses
// rsp_valid_o with the aligned, sign/zero-extended load result (RESP). Misaligned or undefined
// requests skip ACCESS and respond directly without touching memory.
// Ports:
//   clk    : clock, all state updates on posedge
//   rst_n  : synchronous reset, active-HIGH despite the name (1 = reset)
//   lsu_io : lsu_dmem_req_if.slave -- request, data-memory and response signals
module lsu_dmem_req #(
  parameter int unsigned XLEN = 32
) (
  input logic            clk,
  input logic            rst_n,
  lsu_dmem_req_if.slave  lsu_io
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic            ld_q, ld_d;
  logic            cs_q, cs_d;
  logic            wr_q, wr_d;
  logic [3:0]      mask_q, mask_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            ld_mis_q, ld_mis_d;
  logic            st_mis_q, st_mis_d;

  logic            is_ld, is_st, accept, f3_legal, misalign;
  logic [3:0]      req_mask;
  logic [XLEN-1:0] req_wdata;
  logic [XLEN-1:0] rd_shift;
  logic [XLEN-1:0] ld_ext;

  // Request decode; a request with both ld and st set is treated as a load.
  always_comb begin
    is_ld  = lsu_io.req_ld_i;
    is_st  = lsu_io.req_st_i & ~lsu_io.req_ld_i;
    accept = (state_q == StIdle) & lsu_io.req_valid_i & (lsu_io.req_ld_i | lsu_io.req_st_i);

    case (lsu_io.req_funct3_i)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = is_ld;
      default:                f3_legal = 1'b0;
    endcase

    // funct3[1:0] encodes access size: 00 byte, 01 half, 10 word
    case (lsu_io.req_funct3_i[1:0])
      2'b01: begin
        misalign  = lsu_io.req_addr_i[0];
        req_mask  = lsu_io.req_addr_i[1] ? 4'b1100 : 4'b0011;
        req_wdata = {(XLEN/16){lsu_io.req_st_data_i[15:0]}};
      end
      2'b10: begin
        misalign  = (lsu_io.req_addr_i[1:0] != 2'b00);
        req_mask  = 4'b1111;
        req_wdata = lsu_io.req_st_data_i;
      end
      default: begin
        misalign  = 1'b0;
        req_mask  = 4'b0001 << lsu_io.req_addr_i[1:0];
        req_wdata = {(XLEN/8){lsu_io.req_st_data_i[7:0]}};
      end
    endcase
  end

  // Load alignment and extension from the latched offset and funct3.
  always_comb begin
    rd_shift = lsu_io.dmem_data_rd_i >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_ext = {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, rd_shift[7:0]};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
      default: ld_ext = rd_shift;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    f3_d       = f3_q;
    off_d      = off_q;
    ld_d       = ld_q;
    cs_d       = cs_q;
    wr_d       = wr_q;
    mask_d     = mask_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    ld_mis_d   = ld_mis_q;
    st_mis_d   = st_mis_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          f3_d  = lsu_io.req_funct3_i;
          off_d = lsu_io.req_addr_i[1:0];
          ld_d  = is_ld;
          if (!f3_legal) begin
            state_d    = StResp;
            rsp_data_d = '0;
            ld_mis_d   = 1'b0;
            st_mis_d   = 1'b0;
          end else if (misalign) begin
            state_d    = StResp;
            rsp_data_d = '0;
            ld_mis_d   = is_ld;
            st_mis_d   = is_st;
          end else begin
            state_d = StAccess;
            cs_d    = 1'b0;
            wr_d    = ~is_st;
            mask_d  = req_mask;
            addr_d  = lsu_io.req_addr_i;
            wdata_d = req_wdata;
          end
        end
      end
      StAccess: begin
        // Memory read data is asynchronous and valid now; capture it as we leave.
        state_d    = StResp;
        cs_d       = 1'b1;
        wr_d       = 1'b1;
        mask_d     = 4'b0000;
        rsp_data_d = ld_q ? ld_ext : '0;
        ld_mis_d   = 1'b0;
        st_mis_d   = 1'b0;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= StIdle;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      ld_q       <= 1'b0;
      cs_q       <= 1'b1;
      wr_q       <= 1'b1;
      mask_q     <= 4'b0000;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      ld_mis_q   <= 1'b0;
      st_mis_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      ld_q       <= ld_d;
      cs_q       <= cs_d;
      wr_q       <= wr_d;
      mask_q     <= mask_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      ld_mis_q   <= ld_mis_d;
      st_mis_q   <= st_mis_d;
    end
  end

  assign lsu_io.req_ready_o    = (state_q == StIdle) & ~rst_n;
  assign lsu_io.rsp_valid_o    = (state_q == StResp);
  assign lsu_io.dmem_cs_o      = cs_q;
  assign lsu_io.dmem_wr_o      = wr_q;
  assign lsu_io.dmem_mask_o    = mask_q;
  assign lsu_io.dmem_addr_o    = addr_q;
  assign lsu_io.dmem_data_wr_o = wdata_q;
  assign lsu_io.rsp_data_o     = rsp_data_q;
  assign lsu_io.ld_misalign_o  = ld_mis_q;
  assign lsu_io.st_misalign_o  = st_mis_q;

endmodule

// File: tb/tb_lsu_dmem_req.sv
// Bench for lsu_dmem_req: a word memory with negedge-latched writes sits on the dmem port,
// while a byte-array reference model predicts every request's outcome.
module tb_lsu_dmem_req;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_dmem_req_if bus ();

  lsu_dmem_req dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .lsu_io (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int unsigned cs_lows = 0;

  logic [31:0] mem [256];
  logic [7:0]  ref_mem [1024];

  assign bus.dmem_data_rd_i = mem[bus.dmem_addr_o[9:2]];

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (bus.dmem_cs_o === 1'b0 && bus.dmem_wr_o === 1'b0) begin
      for (int b = 0; b < 4; b++)
        if (bus.dmem_mask_o[b]) mem[bus.dmem_addr_o[9:2]][8*b +: 8] <= bus.dmem_data_wr_o[8*b +: 8];
    end
  end

  always @(posedge clk) if (bus.dmem_cs_o === 1'b0) cs_lows <= cs_lows + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One request through the reference model: classify, predict, drive and check.
  task automatic do_req(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data, input string tag);
    bit          is_ld, is_st, legal, mis, acc;
    int          size, idx;
    logic [31:0] exp_mask, exp_wd, exp_rsp;
    int unsigned cs0;
    is_ld = ld;
    is_st = st && !ld;
    if (is_ld) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    else       legal = (f3 <= 3'd2);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis  = legal && ((addr % size) != 0);
    acc  = legal && !mis;
    idx  = int'(addr[9:0]);
    exp_mask = '0;
    for (int i = 0; i < size; i++) exp_mask[int'(addr[1:0]) + i] = 1'b1;
    exp_wd = '0;
    for (int b = 0; b < 4; b++) exp_wd[8*b +: 8] = data[8*(b % size) +: 8];
    exp_rsp = '0;
    if (acc && is_ld) begin
      for (int i = 0; i < size; i++) exp_rsp[8*i +: 8] = ref_mem[idx + i];
      if (!f3[2] && size < 4 && exp_rsp[8*size-1])
        for (int i = size; i < 4; i++) exp_rsp[8*i +: 8] = 8'hFF;
    end
    if (acc && is_st) for (int i = 0; i < size; i++) ref_mem[idx + i] = data[8*i +: 8];

    @(negedge clk);
    chk({tag, " ready idle"}, bus.req_ready_o, 1);
    cs0 = cs_lows;
    bus.req_valid_i   = 1'b1;
    bus.req_ld_i      = ld;
    bus.req_st_i      = st;
    bus.req_funct3_i  = f3;
    bus.req_addr_i    = addr;
    bus.req_st_data_i = data;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    if (acc) begin
      chk({tag, " cs access"}, bus.dmem_cs_o, 0);
      chk({tag, " wr access"}, bus.dmem_wr_o, is_st ? 0 : 1);
      chk({tag, " mask"}, bus.dmem_mask_o, exp_mask);
      chk({tag, " addr"}, bus.dmem_addr_o, addr);
      chk({tag, " data_wr"}, bus.dmem_data_wr_o, exp_wd);
      chk({tag, " rsp early"}, bus.rsp_valid_o, 0);
      chk({tag, " ready busy"}, bus.req_ready_o, 0);
      @(negedge clk);
    end
    chk({tag, " rsp_valid"}, bus.rsp_valid_o, 1);
    chk({tag, " rsp_data"}, bus.rsp_data_o, exp_rsp);
    chk({tag, " ld_mis"}, bus.ld_misalign_o, (mis && is_ld) ? 1 : 0);
    chk({tag, " st_mis"}, bus.st_misalign_o, (mis && is_st) ? 1 : 0);
    chk({tag, " cs resp"}, bus.dmem_cs_o, 1);
    chk({tag, " wr resp"}, bus.dmem_wr_o, 1);
    chk({tag, " mask resp"}, bus.dmem_mask_o, 0);
    @(negedge clk);
    chk({tag, " rsp pulse"}, bus.rsp_valid_o, 0);
    chk({tag, " cs low cycles"}, cs_lows - cs0, acc ? 1 : 0);
  endtask

  initial begin
    logic [31:0] r_addr, r_data;
    int          r_op;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    rst_n             = 1'b1;
    bus.req_valid_i   = 1'b0;
    bus.req_ld_i      = 1'b0;
    bus.req_st_i      = 1'b0;
    bus.req_funct3_i  = 3'b000;
    bus.req_addr_i    = '0;
    bus.req_st_data_i = '0;
    repeat (2) @(negedge clk);
    chk("rst ready", bus.req_ready_o, 0);
    chk("rst cs", bus.dmem_cs_o, 1);
    chk("rst wr", bus.dmem_wr_o, 1);
    chk("rst mask", bus.dmem_mask_o, 0);
    chk("rst addr", bus.dmem_addr_o, 0);
    chk("rst data_wr", bus.dmem_data_wr_o, 0);
    chk("rst rsp_valid", bus.rsp_valid_o, 0);
    chk("rst rsp_data", bus.rsp_data_o, 0);
    chk("rst flags", {bus.ld_misalign_o, bus.st_misalign_o}, 0);
    rst_n = 1'b0;

    do_req(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, "SW 10");
    do_req(1, 0, 3'b010, 32'h10, 32'h0, "LW 10");
    do_req(0, 1, 3'b000, 32'h13, 32'h000000A5, "SB 13");
    do_req(1, 0, 3'b000, 32'h13, 32'h0, "LB 13");
    do_req(1, 0, 3'b100, 32'h13, 32'h0, "LBU 13");
    do_req(0, 1, 3'b001, 32'h22, 32'h00008001, "SH 22");
    do_req(1, 0, 3'b001, 32'h22, 32'h0, "LH 22");
    do_req(1, 0, 3'b101, 32'h22, 32'h0, "LHU 22");
    do_req(1, 0, 3'b010, 32'h11, 32'h0, "LW 11 mis");
    do_req(0, 1, 3'b001, 32'h23, 32'h12345678, "SH 23 mis");
    do_req(1, 0, 3'b010, 32'h20, 32'h0, "LW 20 after mis");
    do_req(1, 1, 3'b010, 32'h10, 32'h55555555, "LD+ST 10");
    do_req(1, 0, 3'b011, 32'h10, 32'h0, "F3 011");
    do_req(0, 1, 3'b100, 32'h14, 32'h0, "ST F3 100");

    // Held-valid back-to-back loads: ready goes 1,0,0 per op.
    @(negedge clk);
    bus.req_valid_i  = 1'b1;
    bus.req_ld_i     = 1'b1;
    bus.req_st_i     = 1'b0;
    bus.req_funct3_i = 3'b010;
    bus.req_addr_i   = 32'h10;
    for (int i = 0; i < 9; i++) begin
      chk("b2b ready", bus.req_ready_o, (i % 3 == 0) ? 1 : 0);
      if (i % 3 == 2)
        chk("b2b rsp_data", bus.rsp_data_o, {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]});
      @(negedge clk);
    end
    bus.req_valid_i = 1'b0;

    for (int n = 0; n < 60; n++) begin
      r_op   = int'($urandom_range(0, 2));
      r_addr = $urandom;
      r_data = $urandom;
      do_req(r_op != 1, r_op != 0, 3'($urandom_range(0, 7)), r_addr, r_data, "rand");
    end

    // Reset while in ACCESS.
    @(negedge clk);
    bus.req_valid_i  = 1'b1;
    bus.req_ld_i     = 1'b1;
    bus.req_st_i     = 1'b0;
    bus.req_funct3_i = 3'b010;
    bus.req_addr_i   = 32'h10;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk("rstacc cs before", bus.dmem_cs_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstacc cs", bus.dmem_cs_o, 1);
    chk("rstacc wr", bus.dmem_wr_o, 1);
    chk("rstacc mask", bus.dmem_mask_o, 0);
    chk("rstacc addr", bus.dmem_addr_o, 0);
    chk("rstacc data_wr", bus.dmem_data_wr_o, 0);
    chk("rstacc rsp_valid", bus.rsp_valid_o, 0);
    chk("rstacc rsp_data", bus.rsp_data_o, 0);
    chk("rstacc flags", {bus.ld_misalign_o, bus.st_misalign_o}, 0);
    chk("rstacc ready", bus.req_ready_o, 0);
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    @(negedge clk);
    chk("rstacc no rsp", bus.rsp_valid_o, 0);
    do_req(1, 0, 3'b010, 32'h10, 32'h0, "LW after rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
